memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_if.sv | 40 ++++
 rtl/memory_stage.sv | 101 ++++++++++
 tb/tb_memory_stage.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// Pipeline bundle for the memory stage: upstream instruction fields, the memory
// response, the writeback handshake and the bypass path back to decode.
interface memory_stage_if;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        valid_i;
    logic [31:0] pc_i;
    logic [4:0]  waddr_i;
    logic [31:0] result_i;
    logic [31:0] eaddr_i;
    logic [31:0] rdata2_i;
    logic        mem_r;
    logic        mem_w;
    logic        wex;
    logic [2:0]  ld_type;
    logic        ready_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        wen_o;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        fwd_ok;

    modport slave (
        input  data_data_ok, data_rdata, valid_i, pc_i, waddr_i, result_i,
               eaddr_i, rdata2_i, mem_r, mem_w, wex, ld_type, ready_i,
        output ready_o, valid_o, pc_o, waddr_o, wdata_o, wen_o,
               fwd_addr, fwd_data, fwd_ok
    );

    modport master (
        output data_data_ok, data_rdata, valid_i, pc_i, waddr_i, result_i,
               eaddr_i, rdata2_i, mem_r, mem_w, wex, ld_type, ready_i,
        input  ready_o, valid_o, pc_o, waddr_o, wdata_o, wen_o,
               fwd_addr, fwd_data, fwd_ok
    );
endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: waits for the data response, aligns/extends load data,
// holds an early response in a one-entry buffer while writeback is stalled.
module memory_stage (
    input  logic           clk,
    input  logic           resetn,
    memory_stage_if.slave  bus
);
    localparam int unsigned DW = 32;
    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LBU = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LHU = 3'd3;
    localparam logic [2:0] LD_LW  = 3'd4;
    localparam logic [2:0] LD_LWL = 3'd5;
    localparam logic [2:0] LD_LWR = 3'd6;

    logic          r_buf_valid;
    logic [DW-1:0] r_buf;
    logic          r_valid_o;
    logic          r_wen_o;
    logic [31:0]   r_pc_o;
    logic [4:0]    r_waddr_o;
    logic [DW-1:0] r_wdata_o;

    logic          w_mem;
    logic          w_done;
    logic          w_capture;
    logic [DW-1:0] w_raw;
    logic [1:0]    w_off;
    logic [4:0]    w_sh;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [DW-1:0] w_load;
    logic [DW-1:0] w_wdata;

    assign w_mem     = bus.mem_r | bus.mem_w;
    assign w_done    = !w_mem || r_buf_valid || bus.data_data_ok;
    assign w_capture = bus.valid_i && w_mem && bus.data_data_ok && !r_buf_valid && !bus.ready_i;
    assign w_raw     = r_buf_valid ? r_buf : bus.data_rdata;
    assign w_off     = bus.eaddr_i[1:0];
    assign w_sh      = {w_off, 3'b000};
    assign w_byte    = 8'(w_raw >> w_sh);
    assign w_half    = 16'(w_raw >> {w_off[1], 4'b0000});

    // Load alignment; shift amounts widened to 6 bits so a 32-bit shift clears the mask.
    always_comb begin
        w_load = w_raw;
        case (bus.ld_type)
            LD_LB:   w_load = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  w_load = {24'd0, w_byte};
            LD_LH:   w_load = {{16{w_half[15]}}, w_half};
            LD_LHU:  w_load = {16'd0, w_half};
            LD_LW:   w_load = w_raw;
            LD_LWL:  w_load = (w_raw << (6'd24 - 6'(w_sh)))
                            | (bus.rdata2_i & (32'hFFFF_FFFF >> (6'(w_sh) + 6'd8)));
            LD_LWR:  w_load = (w_raw >> w_sh)
                            | (bus.rdata2_i & ~(32'hFFFF_FFFF >> w_sh));
            default: w_load = w_raw;
        endcase
    end

    assign w_wdata = bus.mem_r ? w_load : bus.result_i;

    assign bus.ready_o  = !bus.valid_i || (w_done && bus.ready_i);
    assign bus.fwd_addr = bus.valid_i ? bus.waddr_i : 5'd0;
    assign bus.fwd_data = w_wdata;
    assign bus.fwd_ok   = bus.valid_i && w_done && bus.wex;

    // Response buffer and writeback registers; everything holds while ready_i is low.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_buf_valid <= 1'b0;
            r_buf       <= '0;
            r_valid_o   <= 1'b0;
            r_wen_o     <= 1'b0;
            r_pc_o      <= '0;
            r_waddr_o   <= '0;
            r_wdata_o   <= '0;
        end else begin
            if (bus.ready_i) begin
                r_buf_valid <= 1'b0;
            end else if (w_capture) begin
                r_buf_valid <= 1'b1;
                r_buf       <= bus.data_rdata;
            end
            if (bus.ready_i) begin
                r_valid_o <= bus.valid_i && w_done;
                r_wen_o   <= bus.valid_i && w_done && bus.wex;
                r_pc_o    <= bus.pc_i;
                r_waddr_o <= bus.waddr_i;
                r_wdata_o <= w_wdata;
            end
        end
    end

    assign bus.valid_o = r_valid_o;
    assign bus.wen_o   = r_wen_o;
    assign bus.pc_o    = r_pc_o;
    assign bus.waddr_o = r_waddr_o;
    assign bus.wdata_o = r_wdata_o;
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: load-format vector table plus stall, wait and reset sequences,
// with a queue of expected writeback register contents.
module tb_memory_stage;
    logic clk;
    logic resetn;

    memory_stage_if bus ();

    memory_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        wen;
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } out_t;

    typedef struct {
        logic [2:0]  ld;
        logic        mr;
        logic        mw;
        logic        wx;
        logic [31:0] ea;
        logic [31:0] rd;
        logic [31:0] rt;
        logic [31:0] res;
        logic [31:0] exp;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    out_t exp_q[$];
    out_t last_exp;
    out_t nxt;
    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_valid_o"}, 32'(bus.valid_o), 32'(last_exp.valid));
        chk({tag, "_wen_o"},   32'(bus.wen_o),   32'(last_exp.wen));
        chk({tag, "_pc_o"},    bus.pc_o,         last_exp.pc);
        chk({tag, "_waddr_o"}, 32'(bus.waddr_o), 32'(last_exp.waddr));
        chk({tag, "_wdata_o"}, bus.wdata_o,      last_exp.wdata);
    endtask

    // One clock: registers load only when ready_i, so only then is an expectation queued.
    task automatic tick(input string tag);
        if (bus.ready_i) exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) last_exp = exp_q.pop_front();
        check_out(tag);
    endtask

    task automatic reset_tick(input string tag);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        last_exp = '{1'b0, 1'b0, 32'd0, 5'd0, 32'd0};
        check_out(tag);
        chk({tag, "_buf_valid"}, 32'(dut.r_buf_valid), 32'd0);
    endtask

    function automatic vec_t mk(input logic [2:0] ld, input logic mr, input logic mw,
                                input logic wx, input logic [31:0] ea, input logic [31:0] rd,
                                input logic [31:0] rt, input logic [31:0] res,
                                input logic [31:0] exp);
        vec_t v;
        v.ld = ld; v.mr = mr; v.mw = mw; v.wx = wx; v.ea = ea;
        v.rd = rd; v.rt = rt; v.res = res; v.exp = exp;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.valid_i = 1'b0; bus.pc_i = '0; bus.waddr_i = '0; bus.result_i = '0;
        bus.eaddr_i = '0; bus.rdata2_i = '0; bus.mem_r = 1'b0; bus.mem_w = 1'b0;
        bus.wex = 1'b0; bus.ld_type = 3'd4; bus.ready_i = 1'b1;
        bus.data_data_ok = 1'b0; bus.data_rdata = '0;
    endtask

    initial begin
        tbl[0]  = mk(3'd4, 1, 0, 1, 32'h100, 32'h8899AABB, 32'h0,        32'h0,        32'h8899AABB);
        tbl[1]  = mk(3'd0, 1, 0, 1, 32'h102, 32'h0080FF11, 32'h0,        32'h0,        32'hFFFFFF80);
        tbl[2]  = mk(3'd1, 1, 0, 1, 32'h102, 32'h0080FF11, 32'h0,        32'h0,        32'h00000080);
        tbl[3]  = mk(3'd2, 1, 0, 1, 32'h102, 32'h0080FF11, 32'h0,        32'h0,        32'h00000080);
        tbl[4]  = mk(3'd3, 1, 0, 1, 32'h100, 32'h1234F00D, 32'h0,        32'h0,        32'h0000F00D);
        tbl[5]  = mk(3'd2, 1, 0, 1, 32'h100, 32'h1234F00D, 32'h0,        32'h0,        32'hFFFFF00D);
        tbl[6]  = mk(3'd0, 1, 0, 1, 32'h100, 32'h0000007F, 32'h0,        32'h0,        32'h0000007F);
        tbl[7]  = mk(3'd0, 1, 0, 1, 32'h103, 32'h80000000, 32'h0,        32'h0,        32'hFFFFFF80);
        tbl[8]  = mk(3'd1, 1, 0, 1, 32'h101, 32'h0000AB00, 32'h0,        32'h0,        32'h000000AB);
        tbl[9]  = mk(3'd5, 1, 0, 1, 32'h101, 32'h44332211, 32'hAABBCCDD, 32'h0,        32'h2211CCDD);
        tbl[10] = mk(3'd6, 1, 0, 1, 32'h101, 32'h44332211, 32'hAABBCCDD, 32'h0,        32'hAA443322);
        tbl[11] = mk(3'd5, 1, 0, 1, 32'h103, 32'h44332211, 32'hAABBCCDD, 32'h0,        32'h44332211);
        tbl[12] = mk(3'd5, 1, 0, 1, 32'h100, 32'h44332211, 32'hAABBCCDD, 32'h0,        32'h11BBCCDD);
        tbl[13] = mk(3'd5, 1, 0, 1, 32'h102, 32'h44332211, 32'hAABBCCDD, 32'h0,        32'h332211DD);
        tbl[14] = mk(3'd6, 1, 0, 1, 32'h100, 32'h44332211, 32'hAABBCCDD, 32'h0,        32'h44332211);
        tbl[15] = mk(3'd6, 1, 0, 1, 32'h102, 32'h44332211, 32'hAABBCCDD, 32'h0,        32'hAABB4433);
        tbl[16] = mk(3'd6, 1, 0, 1, 32'h103, 32'h44332211, 32'hAABBCCDD, 32'h0,        32'hAABBCC44);
        tbl[17] = mk(3'd0, 0, 0, 1, 32'h0,   32'h0,        32'h0,        32'hCAFEF00D, 32'hCAFEF00D);
        tbl[18] = mk(3'd0, 0, 1, 0, 32'h103, 32'h0,        32'h0,        32'h000055AA, 32'h000055AA);
        tbl[19] = mk(3'd2, 0, 0, 0, 32'h0,   32'hFFFFFFFF, 32'h0,        32'h12345678, 32'h12345678);

        idle_inputs();
        resetn = 1'b0;
        @(posedge clk);
        reset_tick("reset");
        resetn = 1'b1;

        // Idle stage: ready upstream, no bypass address.
        #1;
        chk("idle_ready_o",  32'(bus.ready_o),  32'd1);
        chk("idle_fwd_addr", 32'(bus.fwd_addr), 32'd0);
        chk("idle_fwd_ok",   32'(bus.fwd_ok),   32'd0);

        // Table: every entry completes in one cycle with ready_i high.
        for (int i = 0; i < 20; i++) begin
            bus.valid_i = 1'b1; bus.pc_i = 32'h1000 + 32'(4 * i); bus.waddr_i = 5'(i + 1);
            bus.ld_type = tbl[i].ld; bus.mem_r = tbl[i].mr; bus.mem_w = tbl[i].mw;
            bus.wex = tbl[i].wx; bus.eaddr_i = tbl[i].ea; bus.data_rdata = tbl[i].rd;
            bus.rdata2_i = tbl[i].rt; bus.result_i = tbl[i].res;
            bus.data_data_ok = tbl[i].mr | tbl[i].mw; bus.ready_i = 1'b1;
            #1;
            chk($sformatf("vec%0d_ready_o", i),  32'(bus.ready_o),  32'd1);
            chk($sformatf("vec%0d_fwd_ok", i),   32'(bus.fwd_ok),   32'(tbl[i].wx));
            chk($sformatf("vec%0d_fwd_addr", i), 32'(bus.fwd_addr), 32'(i + 1));
            chk($sformatf("vec%0d_fwd_data", i), bus.fwd_data,      tbl[i].exp);
            nxt = '{1'b1, tbl[i].wx, bus.pc_i, bus.waddr_i, tbl[i].exp};
            tick($sformatf("vec%0d", i));
        end

        // Response during writeback stall is buffered, then released.
        bus.valid_i = 1'b1; bus.pc_i = 32'h2000; bus.waddr_i = 5'd9; bus.ld_type = 3'd4;
        bus.mem_r = 1'b1; bus.mem_w = 1'b0; bus.wex = 1'b1; bus.eaddr_i = 32'h200;
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEADBEEF; bus.ready_i = 1'b0;
        #1;
        chk("buf_c0_ready_o",  32'(bus.ready_o), 32'd0);
        chk("buf_c0_fwd_ok",   32'(bus.fwd_ok),  32'd1);
        tick("buf_c0");
        chk("buf_c0_buf_valid", 32'(dut.r_buf_valid), 32'd1);
        for (int c = 1; c < 3; c++) begin
            bus.data_data_ok = 1'b0; bus.data_rdata = 32'h12345678;
            #1;
            chk($sformatf("buf_c%0d_ready_o", c),  32'(bus.ready_o), 32'd0);
            chk($sformatf("buf_c%0d_fwd_ok", c),   32'(bus.fwd_ok),  32'd1);
            chk($sformatf("buf_c%0d_fwd_data", c), bus.fwd_data,     32'hDEADBEEF);
            tick($sformatf("buf_c%0d", c));
            chk($sformatf("buf_c%0d_buf_valid", c), 32'(dut.r_buf_valid), 32'd1);
        end
        bus.ready_i = 1'b1;
        #1;
        chk("buf_rel_ready_o", 32'(bus.ready_o), 32'd1);
        nxt = '{1'b1, 1'b1, 32'h2000, 5'd9, 32'hDEADBEEF};
        tick("buf_rel");
        chk("buf_rel_buf_valid", 32'(dut.r_buf_valid), 32'd0);

        // Store waits four cycles: bubbles, then one valid non-writing result.
        bus.valid_i = 1'b1; bus.pc_i = 32'h3000; bus.waddr_i = 5'd3; bus.mem_r = 1'b0;
        bus.mem_w = 1'b1; bus.wex = 1'b0; bus.result_i = 32'h000055AA;
        bus.data_data_ok = 1'b0; bus.ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("st_w%0d_ready_o", c), 32'(bus.ready_o), 32'd0);
            nxt = '{1'b0, 1'b0, 32'h3000, 5'd3, 32'h000055AA};
            tick($sformatf("st_w%0d", c));
        end
        bus.data_data_ok = 1'b1;
        #1;
        chk("st_ack_ready_o", 32'(bus.ready_o), 32'd1);
        nxt = '{1'b1, 1'b0, 32'h3000, 5'd3, 32'h000055AA};
        tick("st_ack");

        // Load waits two cycles, then its response bypasses the buffer.
        bus.pc_i = 32'h3100; bus.waddr_i = 5'd12; bus.mem_r = 1'b1; bus.mem_w = 1'b0;
        bus.wex = 1'b1; bus.ld_type = 3'd2; bus.eaddr_i = 32'h302;
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("ld_w%0d_fwd_ok", c), 32'(bus.fwd_ok), 32'd0);
            nxt = '{1'b0, 1'b0, 32'h3100, 5'd12, 32'h0};
            tick($sformatf("ld_w%0d", c));
        end
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h80010000;
        #1;
        nxt = '{1'b1, 1'b1, 32'h3100, 5'd12, 32'hFFFF8001};
        tick("ld_byp");
        chk("ld_byp_buf_valid", 32'(dut.r_buf_valid), 32'd0);

        // Reset while a response sits in the buffer; a stale strobe afterwards is ignored.
        bus.pc_i = 32'h3200; bus.waddr_i = 5'd7; bus.ld_type = 3'd4; bus.eaddr_i = 32'h0;
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hA5A5A5A5; bus.ready_i = 1'b0;
        tick("rst_fill");
        chk("rst_fill_buf_valid", 32'(dut.r_buf_valid), 32'd1);
        bus.data_data_ok = 1'b0;
        reset_tick("rst_mid");
        resetn = 1'b1;
        bus.valid_i = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0000FFFF;
        tick("rst_stale");
        chk("rst_stale_buf_valid", 32'(dut.r_buf_valid), 32'd0);
        bus.data_data_ok = 1'b0; bus.mem_r = 1'b0; bus.wex = 1'b0;
        bus.pc_i = 32'h4000; bus.waddr_i = 5'd4; bus.result_i = 32'h77; bus.ready_i = 1'b1;
        #1;
        chk("post_rst_ready_o", 32'(bus.ready_o), 32'd1);
        nxt = '{1'b0, 1'b0, 32'h4000, 5'd4, 32'h77};
        tick("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
